// File: rtl/mole_board_if.sv
// Signal bundle between the whack-a-mole board controller and its
// stimulus/display side: game inputs, timer handshake and board outputs.
interface mole_board_if #(
  parameter int N_HOLES = 8,
  parameter int SCORE_W = 8
);
  // There is no valid/ready pair. start, btn, time_trigger and timer_load are
  // single-cycle pulses that count only in the cycle they are high. The rest
  // are levels that hold their value until the controller changes them.
  logic                 start;
  logic [N_HOLES-1:0]   btn;
  logic                 time_trigger;
  logic                 timer_load;
  logic [27:0]          timer_loadval;
  logic [N_HOLES-1:0]   mole;
  logic                 hit_flash;
  logic [SCORE_W-1:0]   score;
  logic [2:0]           lives;
  logic                 game_over;

  modport master (
    output start, btn, time_trigger,
    input  timer_load, timer_loadval, mole, hit_flash, score, lives, game_over
  );

  modport slave (
    input  start, btn, time_trigger,
    output timer_load, timer_loadval, mole, hit_flash, score, lives, game_over
  );
endinterface

// File: rtl/mole_board_ctrl.sv
// Whack-a-mole round controller: raises one pseudo-random mole at a time,
// scores hits, deducts lives on misses, and drives the board countdown timer.
module mole_board_ctrl #(
  parameter int          N_HOLES   = 8,
  parameter logic [27:0] SHOW_TIME = 28'd100_000_000,
  parameter logic [27:0] GAP_TIME  = 28'd50_000_000,
  parameter logic [27:0] HIT_TIME  = 28'd25_000_000,
  parameter int          LIVES     = 3,
  parameter int          SCORE_W   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  mole_board_if.slave io_bus,
  output logic [2:0]  o_state
);
  localparam int HW = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GAP  = 3'd1,
    S_SHOW = 3'd2,
    S_HIT  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t             r_state;
  logic [15:0]        r_lfsr;
  logic [HW-1:0]      r_prev_hole;
  logic               r_timer_load;
  logic [27:0]        r_timer_loadval;
  logic [N_HOLES-1:0] r_mole;
  logic               r_hit_flash;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic               r_game_over;

  logic               w_fb;
  logic               w_trig;
  logic               w_hit;
  logic [HW-1:0]      w_cand;
  logic [HW-1:0]      w_hole;
  logic [N_HOLES-1:0] w_onehot;

  assign w_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_cand   = r_lfsr[HW-1:0];
  // Bumping a repeat to the next hole keeps the same hole from showing twice in a row.
  assign w_hole   = (w_cand == r_prev_hole) ? w_cand + HW'(1) : w_cand;
  assign w_onehot = N_HOLES'(1) << w_hole;
  // A trigger arriving while our own load pulse is out belongs to the previous countdown.
  assign w_trig   = io_bus.time_trigger & ~r_timer_load;
  assign w_hit    = |(io_bus.btn & r_mole);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_lfsr          <= LFSR_SEED;
      r_prev_hole     <= '0;
      r_timer_load    <= 1'b0;
      r_timer_loadval <= '0;
      r_mole          <= '0;
      r_hit_flash     <= 1'b0;
      r_score         <= '0;
      r_lives         <= '0;
      r_game_over     <= 1'b0;
    end else begin
      r_lfsr       <= {r_lfsr[14:0], w_fb};
      r_timer_load <= 1'b0;
      case (r_state)
        S_IDLE, S_OVER: begin
          if (io_bus.start) begin
            r_game_over     <= 1'b0;
            r_score         <= '0;
            r_lives         <= 3'(LIVES);
            r_mole          <= '0;
            r_hit_flash     <= 1'b0;
            r_timer_load    <= 1'b1;
            r_timer_loadval <= GAP_TIME;
            r_state         <= S_GAP;
          end
        end
        S_GAP: begin
          if (w_trig) begin
            r_prev_hole     <= w_hole;
            r_mole          <= w_onehot;
            r_timer_load    <= 1'b1;
            r_timer_loadval <= SHOW_TIME;
            r_state         <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (w_hit) begin
            r_score         <= (r_score == '1) ? r_score : r_score + SCORE_W'(1);
            r_mole          <= '0;
            r_hit_flash     <= 1'b1;
            r_timer_load    <= 1'b1;
            r_timer_loadval <= HIT_TIME;
            r_state         <= S_HIT;
          end else if (w_trig) begin
            r_mole <= '0;
            if (r_lives <= 3'd1) begin
              r_lives     <= '0;
              r_game_over <= 1'b1;
              r_state     <= S_OVER;
            end else begin
              r_lives         <= r_lives - 3'd1;
              r_timer_load    <= 1'b1;
              r_timer_loadval <= GAP_TIME;
              r_state         <= S_GAP;
            end
          end
        end
        S_HIT: begin
          if (w_trig) begin
            r_hit_flash     <= 1'b0;
            r_timer_load    <= 1'b1;
            r_timer_loadval <= GAP_TIME;
            r_state         <= S_GAP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.timer_load    = r_timer_load;
  assign io_bus.timer_loadval = r_timer_loadval;
  assign io_bus.mole          = r_mole;
  assign io_bus.hit_flash     = r_hit_flash;
  assign io_bus.score         = r_score;
  assign io_bus.lives         = r_lives;
  assign io_bus.game_over     = r_game_over;
  assign o_state              = r_state;
endmodule

// File: tb/tb_mole_board_ctrl.sv
// Scoreboard bench for mole_board_ctrl: a behavioural game model predicts
// every post-edge output packet, which is queued and compared per scenario.
module tb_mole_board_ctrl;
  localparam int          N_HOLES = 8;
  localparam int          SCORE_W = 2;
  localparam int          LIVES   = 3;
  localparam logic [27:0] GAP_T   = 28'd11;
  localparam logic [27:0] SHOW_T  = 28'd22;
  localparam logic [27:0] HIT_T   = 28'd33;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          W       = 47;
  localparam logic [2:0]  ST_IDLE = 3'd0, ST_GAP = 3'd1, ST_SHOW = 3'd2,
                          ST_HIT = 3'd3, ST_OVER = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;

  mole_board_if #(.N_HOLES(N_HOLES), .SCORE_W(SCORE_W)) bus ();

  mole_board_ctrl #(
    .N_HOLES(N_HOLES), .SHOW_TIME(SHOW_T), .GAP_TIME(GAP_T), .HIT_TIME(HIT_T),
    .LIVES(LIVES), .SCORE_W(SCORE_W), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus),
    .o_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [2:0]         m_st;
  logic               m_tl;
  logic [27:0]        m_lv;
  logic [N_HOLES-1:0] m_mole;
  logic               m_hf;
  logic [SCORE_W-1:0] m_score;
  logic [2:0]         m_lives;
  logic               m_go;
  logic [2:0]         m_prev;
  logic [15:0]        m_lfsr;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int           n_vec = 0;
  int           n_err = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [W-1:0] model_pkt();
    return {m_st, m_tl, m_lv, m_mole, m_hf, m_score, m_lives, m_go};
  endfunction

  function automatic logic [W-1:0] obs_pkt();
    return {dbg_state, bus.timer_load, bus.timer_loadval, bus.mole, bus.hit_flash,
            bus.score, bus.lives, bus.game_over};
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_tl = 1'b0; m_lv = '0; m_mole = '0; m_hf = 1'b0;
    m_score = '0; m_lives = '0; m_go = 1'b0; m_prev = '0;
  endtask

  // Predicts the outputs after the coming edge and queues them.
  task automatic predict(input logic s, input logic [N_HOLES-1:0] b, input logic t);
    logic       qual;
    logic [2:0] cand;
    qual = t && !m_tl;
    m_tl = 1'b0;
    case (m_st)
      ST_IDLE, ST_OVER: if (s) begin
        m_go = 1'b0; m_score = '0; m_lives = 3'(LIVES);
        m_tl = 1'b1; m_lv = GAP_T; m_st = ST_GAP;
      end
      ST_GAP: if (qual) begin
        cand = m_lfsr[2:0];
        if (cand == m_prev) cand = cand + 3'd1;
        m_prev = cand;
        m_mole = 8'b1 << cand;
        m_tl = 1'b1; m_lv = SHOW_T; m_st = ST_SHOW;
      end
      ST_SHOW: begin
        if ((b & m_mole) != '0) begin
          if (m_score != 2'b11) m_score = m_score + 2'd1;
          m_mole = '0; m_hf = 1'b1; m_tl = 1'b1; m_lv = HIT_T; m_st = ST_HIT;
        end else if (qual) begin
          m_mole = '0;
          if (m_lives != 3'd0) m_lives = m_lives - 3'd1;
          if (m_lives == 3'd0) begin
            m_go = 1'b1; m_st = ST_OVER;
          end else begin
            m_tl = 1'b1; m_lv = GAP_T; m_st = ST_GAP;
          end
        end
      end
      ST_HIT: if (qual) begin
        m_hf = 1'b0; m_tl = 1'b1; m_lv = GAP_T; m_st = ST_GAP;
      end
      default: ;
    endcase
    exp_q.push_back(model_pkt());
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic s, input logic [N_HOLES-1:0] b, input logic t);
    predict(s, b, t);
    bus.start = s; bus.btn = b; bus.time_trigger = t;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.btn = '0; bus.time_trigger = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.btn = '0; bus.time_trigger = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.push_back(model_pkt());
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs_pkt() !== exp_v) begin
      n_err++; $display("FAIL reset: got %h expected %h", obs_pkt(), exp_v);
    end
    // Triggers and presses in IDLE must do nothing.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, N_HOLES'($urandom_range(0, 255)), 1'b1);
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL idle_ignore[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  task automatic test_start_show();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(1'b1, '0, 1'b0);   // start -> GAP load
        1: step(1'b0, '0, 1'b1);   // stale trigger while load is high
        2: step(1'b0, '0, 1'b0);
        3: step(1'b0, '0, 1'b1);   // -> SHOW
        default: step(1'b0, '0, 1'b0);
      endcase
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL start_show[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(1'b0, m_mole, 1'b0);        // hit
        1: step(1'b0, '0, 1'b1);            // stale trigger
        2: step(1'b0, {N_HOLES{1'b1}}, 1'b0); // presses in HIT ignored
        3: step(1'b0, '0, 1'b1);            // -> GAP
        default: step(1'b0, '0, 1'b0);
      endcase
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL hit[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  task automatic test_miss_to_over();
    for (int i = 0; i < 18; i++) begin
      if (i < 15) begin
        case (i % 5)
          0: step(1'b0, '0, 1'b0);
          1: step(1'b0, '0, 1'b1);       // -> SHOW
          2: step(1'b0, '0, 1'b0);
          3: step(1'b0, ~m_mole, 1'b0);  // wrong holes only
          default: step(1'b0, '0, 1'b1); // miss
        endcase
      end else begin
        step(1'b0, N_HOLES'($urandom_range(0, 255)), 1'b1); // OVER: no loads
      end
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL miss_over[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
    n_vec++;
    if (bus.game_over !== 1'b1 || bus.lives !== 3'd0) begin
      n_err++; $display("FAIL over_flags: got go=%b lives=%0d expected go=1 lives=0",
                        bus.game_over, bus.lives);
    end
  endtask

  task automatic test_restart();
    for (int i = 0; i < 2; i++) begin
      step(i == 0, '0, 1'b0);
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL restart[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  task automatic test_hit_and_trigger();
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: step(1'b0, '0, 1'b1);      // -> SHOW
        1: step(1'b0, '0, 1'b0);
        2: step(1'b0, m_mole, 1'b1);  // hit wins over trigger
        3: step(1'b0, '0, 1'b1);      // stale
        4: step(1'b0, '0, 1'b0);
        default: step(1'b0, '0, 1'b1); // -> GAP
      endcase
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL hit_trig[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  task automatic test_random_picks();
    logic [N_HOLES-1:0] last_mole;
    last_mole = '0;
    for (int p = 0; p < 64; p++) begin
      for (int i = 0; i < 6; i++) begin
        case (i)
          0: step(1'b0, '0, 1'b0);
          1: step(1'b0, '0, 1'b1);  // pick
          2: step($urandom_range(0, 1) == 1, ~m_mole, 1'b0); // start and wrong presses ignored
          3: step(1'b0, m_mole | N_HOLES'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
          4: step(1'b0, '0, 1'b0);
          default: step(1'b0, '0, 1'b1);
        endcase
        exp_v = exp_q.pop_front(); n_vec++;
        if (obs_pkt() !== exp_v) begin
          n_err++; $display("FAIL pick%0d[%0d]: got %h expected %h", p, i, obs_pkt(), exp_v);
        end
        if (i == 1) begin
          n_vec++;
          if (!$onehot(bus.mole) || bus.mole === last_mole) begin
            n_err++; $display("FAIL pick_onehot%0d: got %b expected one-hot != %b",
                              p, bus.mole, last_mole);
          end
          last_mole = bus.mole;
        end
      end
    end
    n_vec++;
    if (bus.score !== 2'd3) begin
      n_err++; $display("FAIL score_sat: got %0d expected 3", bus.score);
    end
  endtask

  task automatic test_rst_mid_show();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, '0, i == 1);   // second step -> SHOW
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL pre_rst[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    exp_q.push_back(model_pkt());
    exp_v = exp_q.pop_front(); n_vec++;
    if (obs_pkt() !== exp_v) begin
      n_err++; $display("FAIL async_rst: got %h expected %h", obs_pkt(), exp_v);
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.timer_load !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_err++; $display("FAIL rst_hold: got load=%b state=%0d expected load=0 state=0",
                        bus.timer_load, dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(i == 0, '0, i == 2);
      exp_v = exp_q.pop_front(); n_vec++;
      if (obs_pkt() !== exp_v) begin
        n_err++; $display("FAIL post_rst[%0d]: got %h expected %h", i, obs_pkt(), exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_show();
    test_hit();
    test_miss_to_over();
    test_restart();
    test_hit_and_trigger();
    test_random_picks();
    test_rst_mid_show();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
